// File: rtl/data_write_sched_if.sv
// Bus bundle for data_write_sched: refill input (in0), store input (in1)
// and the registered write toward the data array.
// slave  : seen from the scheduler.
// master : seen from whatever drives the requesters and sinks the write.
interface data_write_sched_if;
   logic        io_in_0_valid;
   logic        io_in_0_ready;
   logic [3:0]  io_in_0_bits_way_en;
   logic [11:0] io_in_0_bits_addr;
   logic [63:0] io_in_0_bits_data;
   logic        io_in_0_bits_last;

   logic        io_in_1_valid;
   logic        io_in_1_ready;
   logic [3:0]  io_in_1_bits_way_en;
   logic [11:0] io_in_1_bits_addr;
   logic [63:0] io_in_1_bits_data;

   logic        io_out_ready;
   logic        io_out_valid;
   logic [3:0]  io_out_bits_way_en;
   logic [11:0] io_out_bits_addr;
   logic [63:0] io_out_bits_data;
   logic        io_out_bits_src;

   modport slave (
      input  io_in_0_valid, io_in_0_bits_way_en, io_in_0_bits_addr,
             io_in_0_bits_data, io_in_0_bits_last,
      output io_in_0_ready,
      input  io_in_1_valid, io_in_1_bits_way_en, io_in_1_bits_addr,
             io_in_1_bits_data,
      output io_in_1_ready,
      input  io_out_ready,
      output io_out_valid, io_out_bits_way_en, io_out_bits_addr,
             io_out_bits_data, io_out_bits_src
   );

   modport master (
      output io_in_0_valid, io_in_0_bits_way_en, io_in_0_bits_addr,
             io_in_0_bits_data, io_in_0_bits_last,
      input  io_in_0_ready,
      output io_in_1_valid, io_in_1_bits_way_en, io_in_1_bits_addr,
             io_in_1_bits_data,
      input  io_in_1_ready,
      output io_out_ready,
      input  io_out_valid, io_out_bits_way_en, io_out_bits_addr,
             io_out_bits_data, io_out_bits_src
   );
endinterface

// File: rtl/data_write_sched.sv
// data_write_sched: arbitrates refill beats (in0) and store writes (in1) into
// a single registered write stage toward the data array. Refill wins in
// arbitration and owns the port for the whole burst once it has started.
// Optional macro DATA_WRITE_SCHED_STARVE_EN adds a starvation guard: once the
// store has waited STARVE_LIMIT cycles it is granted ahead of a refill
// (outside bursts only).
module data_write_sched #(
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic              clock,
   input  logic              reset,
   data_write_sched_if.slave io
);

   typedef enum logic [0:0] {
      ARB   = 1'b0,
      BURST = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic        out_valid_q, out_valid_d;
   logic        src_q, src_d;
   logic [3:0]  way_en_q, way_en_d;
   logic [11:0] addr_q, addr_d;
   logic [63:0] data_q, data_d;

   logic        stage_ready_s;
   logic        grant_0_s, grant_1_s;
   logic        ready_0_s, ready_1_s;
   logic        fire_0_s, fire_1_s;
   logic        starve_hit_s;

`ifdef DATA_WRITE_SCHED_STARVE_EN
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   logic [3:0]  starve_cnt_q, starve_cnt_d;
`endif

   // Grant, handshake, next state, stage load and starvation counter.
   always_comb begin
      stage_ready_s = ~out_valid_q | io.io_out_ready;
      starve_hit_s  = 1'b0;
`ifdef DATA_WRITE_SCHED_STARVE_EN
      starve_hit_s  = (starve_cnt_q == LIMIT) & io.io_in_1_valid;
`endif
      grant_0_s = 1'b0;
      grant_1_s = 1'b0;
      case (state_q)
         ARB: begin
            grant_0_s = io.io_in_0_valid & ~starve_hit_s;
            grant_1_s = ~grant_0_s;
         end
         BURST: begin
            grant_0_s = 1'b1;
            grant_1_s = 1'b0;
         end
         default: begin
            grant_0_s = 1'b0;
            grant_1_s = 1'b0;
         end
      endcase
      ready_0_s = grant_0_s & stage_ready_s;
      ready_1_s = grant_1_s & stage_ready_s;
      fire_0_s  = io.io_in_0_valid & ready_0_s;
      fire_1_s  = io.io_in_1_valid & ready_1_s;

      state_d = state_q;
      case (state_q)
         ARB: begin
            if (fire_0_s && !io.io_in_0_bits_last) state_d = BURST;
            else                                  state_d = ARB;
         end
         BURST: begin
            if (fire_0_s && io.io_in_0_bits_last) state_d = ARB;
            else                                 state_d = BURST;
         end
         default: state_d = ARB;
      endcase

      out_valid_d = out_valid_q;
      src_d       = src_q;
      way_en_d    = way_en_q;
      addr_d      = addr_q;
      data_d      = data_q;
      if (fire_0_s) begin
         out_valid_d = 1'b1;
         src_d       = 1'b0;
         way_en_d    = io.io_in_0_bits_way_en;
         addr_d      = io.io_in_0_bits_addr;
         data_d      = io.io_in_0_bits_data;
      end else if (fire_1_s) begin
         out_valid_d = 1'b1;
         src_d       = 1'b1;
         way_en_d    = io.io_in_1_bits_way_en;
         addr_d      = io.io_in_1_bits_addr;
         data_d      = io.io_in_1_bits_data;
      end else if (io.io_out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end

`ifdef DATA_WRITE_SCHED_STARVE_EN
      // Counts consecutive blocked cycles of a waiting store.
      if (!io.io_in_1_valid || fire_1_s) starve_cnt_d = 4'd0;
      else if (starve_cnt_q < LIMIT)     starve_cnt_d = starve_cnt_q + 4'd1;
      else                               starve_cnt_d = starve_cnt_q;
`endif
   end

   // Control state: FSM, stage valid, source tag and starvation counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ARB;
         out_valid_q  <= 1'b0;
         src_q        <= 1'b0;
`ifdef DATA_WRITE_SCHED_STARVE_EN
         starve_cnt_q <= 4'd0;
`endif
      end else begin
         state_q      <= state_d;
         out_valid_q  <= out_valid_d;
         src_q        <= src_d;
`ifdef DATA_WRITE_SCHED_STARVE_EN
         starve_cnt_q <= starve_cnt_d;
`endif
      end
   end

   // Payload holding register; contents are meaningless while the stage is empty.
   always_ff @(posedge clock) begin
      way_en_q <= way_en_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
   end

   assign io.io_in_0_ready      = ready_0_s;
   assign io.io_in_1_ready      = ready_1_s;
   assign io.io_out_valid       = out_valid_q;
   assign io.io_out_bits_src    = src_q;
   assign io.io_out_bits_way_en = way_en_q;
   assign io.io_out_bits_addr   = addr_q;
   assign io.io_out_bits_data   = data_q;

endmodule

// File: doc/data_write_sched.md
DATA_WRITE_SCHED -- requirements
Module: data_write_sched

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, range 1..15: cycles requester 1 may be blocked before it takes priority.
REQ-002 SHALL have port clock  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port io_in_0_valid  input  1  refill beat request.
REQ-005 SHALL have ports io_in_0_bits_way_en / io_in_0_bits_addr / io_in_0_bits_data  input  4 / 12 / 64  refill payload.
REQ-006 SHALL have port io_in_0_bits_last  input  1  final beat of refill burst.
REQ-007 SHALL have port io_in_0_ready  output  1  refill beat accepted when high with valid.
REQ-008 SHALL have ports io_in_1_valid, io_in_1_bits_way_en, io_in_1_bits_addr, io_in_1_bits_data  input  1/4/12/64  store write request.
REQ-009 SHALL have port io_in_1_ready  output  1  store accepted when high with valid.
REQ-010 SHALL have port io_out_ready  input  1  data array accepts write.
REQ-011 SHALL have ports io_out_valid, io_out_bits_way_en, io_out_bits_addr, io_out_bits_data  output  1/4/12/64  registered write to data array.
REQ-012 SHALL have port io_out_bits_src  output  1  source of held write (0 = refill, 1 = store).

Function
REQ-013 SHALL hold one output stage register; stage_ready = ~io_out_valid | io_out_ready.
REQ-014 SHALL have a two-state FSM: ARB, BURST.
REQ-015 In ARB, grant goes to in0 if io_in_0_valid, else to in1; the exception is REQ-021.
REQ-016 In BURST, grant goes only to in0; io_in_1_ready SHALL be 0.
REQ-017 io_in_N_ready SHALL be grant_N & stage_ready; a beat fires when valid & ready.
REQ-018 On any fire, the stage SHALL load the payload and src at the next edge, with io_out_valid=1; latency is exactly 1 cycle from fire to io_out_valid.
REQ-019 If there is no fire and io_out_ready=1, io_out_valid SHALL clear; a simultaneous drain and load SHALL keep io_out_valid=1 with the new payload (full throughput).
REQ-020 Transitions: ARB->BURST on an in0 fire with last=0; BURST->ARB on an in0 fire with last=1; an in0 fire with last=1 in ARB stays in ARB.
REQ-021 (starvation guard) In ARB with starve_cnt==STARVE_LIMIT and io_in_1_valid=1, grant SHALL go to in1 even if in0 is valid.
REQ-022 starve_cnt (4-bit) behaviour:
- increments each cycle io_in_1_valid=1 without an in1 fire, saturating at STARVE_LIMIT;
- clears on an in1 fire or when io_in_1_valid=0;
- holds in BURST except for the saturating increment.
REQ-023 While io_out_valid=1 and io_out_ready=0, output payload and src SHALL be stable.
REQ-024 Payload SHALL NOT be modified; widths pass through unchanged.

Reset
REQ-025 On reset assertion, asynchronously: io_out_valid=0, FSM=ARB, starve_cnt=0, io_out_bits_src=0.
REQ-026 The payload register need not be reset; outputs SHALL be don't-care while io_out_valid=0.
REQ-027 Reset mid-burst SHALL abandon the burst; after release the FSM is in ARB and no partial beat is emitted.

Configuration
REQ-028 Macro DATA_WRITE_SCHED_STARVE_EN: when defined, REQ-021/REQ-022 are implemented; when undefined, starve_cnt is absent and arbitration is pure in0-priority with burst lock.

Verification
REQ-029 Both valid in ARB, in0 last=1, io_out_ready=1 -> in0 granted, next cycle io_out_valid=1 and src=0; in1 waits.
REQ-030 In0 4-beat burst (last on beat 4, addr 0x100..0x103) with in1 valid throughout -> io_in_1_ready=0 for all 4 beats; in1 fires the cycle after beat 4.
REQ-031 io_out_ready=0 for 3 cycles with a held write of addr 0x0AB -> io_in_0_ready=io_in_1_ready=0 and payload stable; a release drains and loads in the same cycle.
REQ-032 With the macro defined and STARVE_LIMIT=8, in0 valid with last=1 continuously and in1 valid -> in1 fires on cycle 9; starve_cnt then reads 0.
REQ-033 Reset asserted mid-burst after beat 2 -> io_out_valid=0 immediately; after release, in1 is granted if in0 is idle.
REQ-034 Macro undefined, same stimulus as REQ-032 -> in1 never granted while in0 is valid.
